// File: rtl/ste_avg_bcd_conv.sv
// rtl/ste_avg_bcd_conv.sv - sequential double-dabble binary-to-BCD converter with one-deep pending buffer
module ste_avg_bcd_conv #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din_i,
    input  logic                  din_update_i,
    input  logic                  clr_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_update_o,
    output logic                  busy_o,
    output logic                  overrun_o
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAX_IN = (longint'(1) << DATA_W) - 1;

    generate
        if (pow10(DIGITS) <= MAX_IN) begin : g_digits_too_few
            $error("ste_avg_bcd_conv: DIGITS too small for DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_bin, r_pend, w_load_val;
    logic [BW-1:0]       r_acc, w_acc_adj, r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_pend_v, w_pend_v_nxt, w_pend_wr, w_load, w_ovr_set;
    logic                r_bcd_upd, r_busy, r_overrun;

    // Per-digit add-3 correction; each nibble is independent, no carry between digits
    always_comb begin
        w_acc_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5)
                w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_val   = din_i;
        w_pend_v_nxt = r_pend_v;
        w_pend_wr    = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_v) begin
                    w_load       = 1'b1;
                    w_load_val   = r_pend;
                    w_pend_v_nxt = din_update_i;
                    w_pend_wr    = din_update_i;
                    w_state_nxt  = S_SHIFT;
                end else if (din_update_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Samples arriving mid-conversion park in pending; newest one wins
        if (r_state != S_IDLE && din_update_i) begin
            w_pend_wr    = 1'b1;
            w_pend_v_nxt = 1'b1;
            w_ovr_set    = r_pend_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            r_bcd     <= '0;
            r_bcd_upd <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_v  <= w_pend_v_nxt;
            r_overrun <= r_overrun | w_ovr_set;
            r_busy    <= (w_state_nxt != S_IDLE) | w_pend_v_nxt;
            r_bcd_upd <= (r_state == S_DONE);
            if (w_pend_wr)
                r_pend <= din_i;
            if (r_state == S_DONE)
                r_bcd <= r_acc;
            if (w_load) begin
                r_bin <= w_load_val;
                r_acc <= '0;
                r_cnt <= CW'(DATA_W);
            end else if (r_state == S_SHIFT) begin
                {r_acc, r_bin} <= {w_acc_adj, r_bin} << 1;
                r_cnt          <= r_cnt - CW'(1);
            end
        end
    end

    assign bcd_o        = r_bcd;
    assign bcd_update_o = r_bcd_upd;
    assign busy_o       = r_busy;
    assign overrun_o    = r_overrun;
endmodule

// File: tb/tb_ste_avg_bcd_conv.sv
// tb/tb_ste_avg_bcd_conv.sv - randomized and directed bench for ste_avg_bcd_conv against a timing/arithmetic model
module tb_ste_avg_bcd_conv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_a = '0;
    logic        up_a = 1'b0, clr_a = 1'b0;
    logic [19:0] bcd_a;
    logic        upd_a, busy_a, ovr_a;
    logic [7:0]  din_b = '0;
    logic        up_b = 1'b0, clr_b = 1'b0;
    logic [11:0] bcd_b;
    logic        upd_b, busy_b, ovr_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ste_avg_bcd_conv #(.DATA_W(16), .DIGITS(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .din_i(din_a), .din_update_i(up_a), .clr_i(clr_a),
        .bcd_o(bcd_a), .bcd_update_o(upd_a), .busy_o(busy_a), .overrun_o(ovr_a));

    ste_avg_bcd_conv #(.DATA_W(8), .DIGITS(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din_i(din_b), .din_update_i(up_b), .clr_i(clr_b),
        .bcd_o(bcd_b), .bcd_update_o(upd_b), .busy_o(busy_b), .overrun_o(ovr_b));

    // Model: a conversion started at edge E yields its result at E+DATA_W+1; the
    // converter is free again one edge later; one pending slot, newest wins.
    bit          m_conv[2], m_pend_v[2], m_ovr[2], m_upd[2], m_busy[2];
    int          m_t[2], m_val[2], m_pend[2];
    logic [19:0] m_bcd[2];

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k, input bit rn, input bit cl, input bit up, input int din, input int dw);
        bit was_busy;
        if (!rn || cl) begin
            m_conv[k] = 0; m_t[k] = 0; m_pend_v[k] = 0; m_ovr[k] = 0;
            m_bcd[k] = '0; m_upd[k] = 0;
        end else begin
            was_busy = m_conv[k];
            m_upd[k] = 0;
            if (!was_busy) begin
                if (m_pend_v[k]) begin
                    m_conv[k] = 1; m_t[k] = 0; m_val[k] = m_pend[k];
                    m_pend_v[k] = up;
                    if (up) m_pend[k] = din;
                end else if (up) begin
                    m_conv[k] = 1; m_t[k] = 0; m_val[k] = din;
                end
            end else begin
                if (up) begin
                    if (m_pend_v[k]) m_ovr[k] = 1;
                    m_pend_v[k] = 1;
                    m_pend[k] = din;
                end
                m_t[k]++;
                if (m_t[k] == dw + 1) begin
                    m_bcd[k] = to_bcd(m_val[k]);
                    m_upd[k] = 1;
                    m_conv[k] = 0;
                end
            end
        end
        m_busy[k] = m_conv[k] || m_pend_v[k];
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, rst_n, clr_a, up_a, int'(din_a), 16);
        model_step(1, rst_n, clr_b, up_b, int'(din_b), 8);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("A_bcd",  32'(bcd_a),  32'(m_bcd[0]));
            check("A_upd",  32'(upd_a),  32'(m_upd[0]));
            check("A_busy", 32'(busy_a), 32'(m_busy[0]));
            check("A_ovr",  32'(ovr_a),  32'(m_ovr[0]));
            check("B_bcd",  32'(bcd_b),  32'(m_bcd[1]));
            check("B_upd",  32'(upd_b),  32'(m_upd[1]));
            check("B_busy", 32'(busy_b), 32'(m_busy[1]));
            check("B_ovr",  32'(ovr_b),  32'(m_ovr[1]));
        end
    end

    typedef struct {int c; logic [19:0] v;} pulse_t;
    pulse_t q_a[$];

    always @(negedge clk) begin
        if (upd_a) q_a.push_back('{c: cyc, v: bcd_a});
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic strobe_a(input int v);
        din_a = 16'(v);
        up_a  = 1'b1;
        tick();
        up_a  = 1'b0;
    endtask

    int sc;
    int perm[256];
    int lat;
    bit got;

    initial begin
        check("model_65535", 32'(to_bcd(65535)), 32'h65535);
        check("model_678",   32'(to_bcd(678)),   32'h00678);
        check("model_0",     32'(to_bcd(0)),     32'h00000);

        rst_n = 1'b0;
        tick(3);
        chk_en = 1'b1;
        check("reset_bcd",  32'(bcd_a), 32'h0);
        check("reset_upd",  32'(upd_a), 32'h0);
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_ovr",  32'(ovr_a), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // T1 / T2: single conversions, latency 17
        q_a.delete();
        strobe_a(0); sc = cyc;
        tick(30);
        check("T1_npulse", 32'(q_a.size()), 32'd1);
        if (q_a.size() >= 1) begin
            check("T1_val", 32'(q_a[0].v), 32'h00000);
            check("T1_lat", 32'(q_a[0].c - sc), 32'd17);
        end
        q_a.delete();
        strobe_a(65535); sc = cyc;
        tick(30);
        check("T2_npulse", 32'(q_a.size()), 32'd1);
        if (q_a.size() >= 1) begin
            check("T2_val", 32'(q_a[0].v), 32'h65535);
            check("T2_lat", 32'(q_a[0].c - sc), 32'd17);
        end

        // T3: second sample parked in pending, results 18 clocks apart
        q_a.delete();
        strobe_a(12345);
        tick(4);
        strobe_a(678);
        tick(50);
        check("T3_npulse", 32'(q_a.size()), 32'd2);
        if (q_a.size() >= 2) begin
            check("T3_val0", 32'(q_a[0].v), 32'h12345);
            check("T3_val1", 32'(q_a[1].v), 32'h00678);
            check("T3_gap",  32'(q_a[1].c - q_a[0].c), 32'd18);
        end
        check("T3_ovr", 32'(ovr_a), 32'h0);

        // T4: overrun, newest pending sample wins
        q_a.delete();
        strobe_a(1111);
        strobe_a(100);
        strobe_a(200);
        strobe_a(300);
        check("T4_ovr", 32'(ovr_a), 32'h1);
        tick(50);
        check("T4_npulse", 32'(q_a.size()), 32'd2);
        if (q_a.size() >= 2) begin
            check("T4_val0", 32'(q_a[0].v), 32'h01111);
            check("T4_val1", 32'(q_a[1].v), 32'h00300);
        end
        check("T4_busy_end", 32'(busy_a), 32'h0);

        // T5: clear mid-conversion, clear with strobe, reset mid-conversion
        q_a.delete();
        strobe_a(4321);
        tick(6);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("T5_clr_bcd",  32'(bcd_a), 32'h0);
        check("T5_clr_busy", 32'(busy_a), 32'h0);
        check("T5_clr_ovr",  32'(ovr_a), 32'h0);
        tick(30);
        din_a = 16'd55; up_a = 1'b1; clr_a = 1'b1;
        tick();
        up_a = 1'b0; clr_a = 1'b0;
        tick(30);
        check("T5_clr_npulse", 32'(q_a.size()), 32'd0);
        strobe_a(4321);
        strobe_a(1);
        strobe_a(2);
        check("T5_pre_rst_ovr", 32'(ovr_a), 32'h1);
        tick(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("T5_rst_ovr",  32'(ovr_a), 32'h0);
        check("T5_rst_busy", 32'(busy_a), 32'h0);
        tick(30);
        check("T5_rst_npulse", 32'(q_a.size()), 32'd0);

        // Random traffic on the 16-bit instance, model-checked every cycle
        for (int i = 0; i < 2500; i++) begin
            up_a  = ($urandom_range(0, 9) < 2);
            case ($urandom_range(0, 7))
                0:       din_a = 16'h0000;
                1:       din_a = 16'hFFFF;
                default: din_a = 16'($urandom);
            endcase
            clr_a = ($urandom_range(0, 299) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        up_a = 1'b0; clr_a = 1'b0; rst_n = 1'b1;
        tick(25);

        // T6: 8-bit instance, shuffled sweep 0..255, back-to-back
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            din_b = 8'(perm[i]);
            up_b  = 1'b1;
            tick();
            up_b  = 1'b0;
            got = 1'b0;
            lat = 0;
            for (int w = 0; w < 30 && !got; w++) begin
                tick();
                lat++;
                if (upd_b) got = 1'b1;
            end
            if (!got) begin
                n_tests++;
                n_fail++;
                $display("FAIL T6_timeout: no result for %0d within 30 cycles", perm[i]);
            end else begin
                check("T6_val", 32'(bcd_b), 32'(to_bcd(perm[i])));
                check("T6_lat", 32'(lat), 32'd9);
            end
        end
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
